// File: rtl/ihp_sram_ctrl_pkg.sv
// rtl/ihp_sram_ctrl_pkg.sv - shared types, default widths and sizing helper for the SRAM request controller
package ihp_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        CLEAR    = 2'd1,
        READY    = 2'd2
    } ctrl_state_e;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_RSP_DEPTH = 4;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ihp_sram_rsp_fifo.sv
// rtl/ihp_sram_rsp_fifo.sv - first-word-fall-through response FIFO with occupancy count and flush
module ihp_sram_rsp_fifo
    import ihp_sram_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RSP_DEPTH = DEF_RSP_DEPTH,
    localparam int PTR_W    = log2(RSP_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop, full;

    assign full    = (cnt_q == CNT_W'(RSP_DEPTH));
    assign valid   = (cnt_q != '0);
    assign count   = cnt_q;
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rdata   = valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    // Upstream credit accounting must never present a push to a full FIFO.
    assert property (@(posedge clk) disable iff (!rst_n) (push && !flush) |-> (!full || pop));

endmodule

// File: rtl/ihp_sram_req_ctrl.sv
// rtl/ihp_sram_req_ctrl.sv - request stream to registered SRAM strobes, zero-fill and credit-guarded read return
module ihp_sram_req_ctrl
    import ihp_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int RSP_DEPTH      = DEF_RSP_DEPTH,
    parameter int CLEAR_ON_START = 1
) (
    input  logic              UserCLK,
    input  logic              rst_n,
    input  logic              configured,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_bmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic [DATA_W-1:0] sram_bm,
    output logic              sram_wen,
    output logic              sram_men,
    output logic              sram_ren,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int CNT_W = log2(RSP_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d, addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d, bm_q, bm_d;
    logic              wen_q, wen_d, men_q, men_d, ren_q, ren_d;
    logic              rd_dout_q, rd_dout_d;
    logic              flush, req_fire;
    logic [CNT_W-1:0]  fifo_count;
    logic [SUM_W-1:0]  credit_used;

    // A read holds a credit from accept until its data leaves the FIFO.
    assign credit_used = SUM_W'(fifo_count) + SUM_W'(ren_q) + SUM_W'(rd_dout_q);
    assign req_ready   = configured && (state_q == READY) && (credit_used < SUM_W'(RSP_DEPTH));
    assign req_fire    = req_valid && req_ready;
    assign clear_busy  = (state_q == CLEAR);

    assign sram_addr = addr_q;
    assign sram_din  = din_q;
    assign sram_bm   = bm_q;
    assign sram_wen  = wen_q;
    assign sram_men  = men_q;
    assign sram_ren  = ren_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        addr_d    = addr_q;
        din_d     = din_q;
        bm_d      = bm_q;
        wen_d     = 1'b0;
        men_d     = 1'b0;
        ren_d     = 1'b0;
        rd_dout_d = ren_q;
        flush     = 1'b0;
        if (!configured) begin
            state_d   = WAIT_CFG;
            clr_cnt_d = '0;
            rd_dout_d = 1'b0;
            flush     = 1'b1;
        end else begin
            case (state_q)
                WAIT_CFG: state_d = (CLEAR_ON_START != 0) ? CLEAR : READY;
                CLEAR: begin
                    addr_d    = clr_cnt_q;
                    din_d     = '0;
                    bm_d      = '1;
                    wen_d     = 1'b1;
                    men_d     = 1'b1;
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == '1) state_d = READY;
                end
                READY: begin
                    if (req_fire) begin
                        addr_d = req_addr;
                        din_d  = req_wdata;
                        bm_d   = req_bmask;
                        wen_d  = req_we;
                        ren_d  = !req_we;
                        men_d  = 1'b1;
                    end
                end
                default: state_d = WAIT_CFG;
            endcase
        end
    end

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_CFG;
            clr_cnt_q <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            bm_q      <= '0;
            wen_q     <= 1'b0;
            men_q     <= 1'b0;
            ren_q     <= 1'b0;
            rd_dout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            bm_q      <= bm_d;
            wen_q     <= wen_d;
            men_q     <= men_d;
            ren_q     <= ren_d;
            rd_dout_q <= rd_dout_d;
        end
    end

    ihp_sram_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (UserCLK),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (rd_dout_q),
        .push_data (sram_dout),
        .pop       (rsp_valid && rsp_ready),
        .rdata     (rsp_rdata),
        .valid     (rsp_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ihp_sram_req_ctrl.sv
// tb/tb_ihp_sram_req_ctrl.sv - directed self-checking bench for ihp_sram_req_ctrl with a bit-masked SRAM model
module tb_ihp_sram_req_ctrl;

    logic        UserCLK    = 1'b0;
    logic        rst_n      = 1'b0;
    logic        configured = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_we     = 1'b0;
    logic [9:0]  req_addr   = '0;
    logic [31:0] req_wdata  = '0;
    logic [31:0] req_bmask  = '0;
    logic        rsp_ready  = 1'b0;
    logic        req_ready, rsp_valid, clear_busy;
    logic [31:0] rsp_rdata;
    logic [9:0]  sram_addr;
    logic [31:0] sram_din, sram_bm;
    logic        sram_wen, sram_men, sram_ren;
    logic [31:0] sram_dout = '0;
    logic [31:0] mem [1024] = '{default: 32'hA5A5A5A5};

    int checks   = 0;
    int failures = 0;

    ihp_sram_req_ctrl dut (
        .UserCLK    (UserCLK),
        .rst_n      (rst_n),
        .configured (configured),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_bmask  (req_bmask),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .clear_busy (clear_busy),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_bm    (sram_bm),
        .sram_wen   (sram_wen),
        .sram_men   (sram_men),
        .sram_ren   (sram_ren),
        .sram_dout  (sram_dout)
    );

    always #5 UserCLK = ~UserCLK;

    always @(posedge UserCLK) begin
        if (sram_men && sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
        if (sram_men && sram_ren) sram_dout <= mem[sram_addr];
    end

    function automatic logic [31:0] wdat(input int i);
        return 32'(32'h1111_1111 * (i + 1));
    endfunction

    task automatic cyc();
        @(posedge UserCLK);
        @(negedge UserCLK);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        configured = 1'b0;
        repeat (3) cyc();
        checks++;
        if (sram_addr !== 0 || sram_din !== 0 || sram_bm !== 0 || sram_wen !== 0 || sram_men !== 0 || sram_ren !== 0) begin
            failures++;
            $display("FAIL reset_strobes got addr=%h din=%h bm=%h wen=%b men=%b ren=%b exp all 0", sram_addr, sram_din, sram_bm, sram_wen, sram_men, sram_ren);
        end
        checks++;
        if (req_ready !== 0 || rsp_valid !== 0 || clear_busy !== 0 || rsp_rdata !== 0) begin
            failures++;
            $display("FAIL reset_status got ready=%b rvalid=%b busy=%b rdata=%h exp all 0", req_ready, rsp_valid, clear_busy, rsp_rdata);
        end
        rst_n = 1'b1;
        repeat (2) cyc();
        checks++;
        if (clear_busy !== 0 || req_ready !== 0 || sram_men !== 0) begin
            failures++;
            $display("FAIL wait_cfg_idle got busy=%b ready=%b men=%b exp 0 0 0", clear_busy, req_ready, sram_men);
        end
    endtask

    task automatic test_clear();
        int  busy;
        int  writes;
        bit  done;
        busy = 0;
        writes = 0;
        done = 1'b0;
        configured = 1'b1;
        for (int n = 0; n < 1100 && !done; n++) begin
            cyc();
            if (clear_busy) busy++;
            if (sram_men) begin
                checks++;
                if (sram_addr !== 10'(writes) || sram_wen !== 1 || sram_ren !== 0 || sram_din !== 0 || sram_bm !== 32'hFFFF_FFFF) begin
                    failures++;
                    $display("FAIL clear_write idx=%0d got addr=%h wen=%b ren=%b din=%h bm=%h exp addr=%h wen=1 ren=0 din=0 bm=ffffffff",
                             writes, sram_addr, sram_wen, sram_ren, sram_din, sram_bm, 10'(writes));
                end
                writes++;
            end
            if (req_ready) done = 1'b1;
        end
        checks++;
        if (busy != 1024) begin
            failures++;
            $display("FAIL clear_busy_cycles got %0d exp 1024", busy);
        end
        checks++;
        if (writes != 1024) begin
            failures++;
            $display("FAIL clear_write_count got %0d exp 1024", writes);
        end
        checks++;
        if (!done || sram_addr !== 10'h3FF || sram_wen !== 1 || clear_busy !== 0) begin
            failures++;
            $display("FAIL clear_ready_rise got ready_seen=%b addr=%h wen=%b busy=%b exp 1 3ff 1 0", done, sram_addr, sram_wen, clear_busy);
        end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h005;
        req_wdata = 32'hDEAD_BEEF; req_bmask = 32'hFFFF_0000;
        checks++;
        if (req_ready !== 1) begin
            failures++;
            $display("FAIL wr_ready got %b exp 1", req_ready);
        end
        cyc();
        checks++;
        if (sram_men !== 1 || sram_wen !== 1 || sram_ren !== 0 || sram_addr !== 10'h005 || sram_din !== 32'hDEAD_BEEF || sram_bm !== 32'hFFFF_0000) begin
            failures++;
            $display("FAIL wr_strobes got men=%b wen=%b ren=%b addr=%h din=%h bm=%h exp 1 1 0 005 deadbeef ffff0000",
                     sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm);
        end
        req_we = 1'b0;
        cyc();
        req_valid = 1'b0;
        checks++;
        if (sram_men !== 1 || sram_wen !== 0 || sram_ren !== 1 || sram_addr !== 10'h005) begin
            failures++;
            $display("FAIL rd_strobes got men=%b wen=%b ren=%b addr=%h exp 1 0 1 005", sram_men, sram_wen, sram_ren, sram_addr);
        end
        cyc();
        checks++;
        if (rsp_valid !== 0 || sram_men !== 0) begin
            failures++;
            $display("FAIL rd_latency_early got rvalid=%b men=%b exp 0 0", rsp_valid, sram_men);
        end
        cyc();
        checks++;
        if (rsp_valid !== 1 || rsp_rdata !== 32'hDEAD_0000) begin
            failures++;
            $display("FAIL rd_after_wr got rvalid=%b rdata=%h exp 1 dead0000", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        cyc();
        checks++;
        if (rsp_valid !== 0) begin
            failures++;
            $display("FAIL rd_pop got rvalid=%b exp 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  rd_addr [8];
        logic [31:0] exp [8];
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 10'(16 + i);
            req_wdata = wdat(i); req_bmask = '1;
            checks++;
            if (req_ready !== 1) begin
                failures++;
                $display("FAIL b2b_wr_ready i=%0d got %b exp 1", i, req_ready);
            end
            cyc();
        end
        req_valid = 1'b0;
        cyc();
        for (int i = 0; i < 7; i++) begin
            rd_addr[i] = 10'(16 + i);
            exp[i] = wdat(i);
        end
        rd_addr[7] = 10'h3FF;
        exp[7] = 32'h0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = rd_addr[c];
                checks++;
                if (req_ready !== 1) begin
                    failures++;
                    $display("FAIL b2b_rd_ready c=%0d got %b exp 1", c, req_ready);
                end
            end else begin
                req_valid = 1'b0;
            end
            if (c >= 3 && c < 11) begin
                checks++;
                if (rsp_valid !== 1 || rsp_rdata !== exp[c-3]) begin
                    failures++;
                    $display("FAIL b2b_rsp k=%0d got rvalid=%b rdata=%h exp 1 %h", c - 3, rsp_valid, rsp_rdata, exp[c-3]);
                end
            end
            cyc();
        end
        checks++;
        if (rsp_valid !== 0) begin
            failures++;
            $display("FAIL b2b_drained got rvalid=%b exp 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        int got;
        bit fire;
        idx = 0;
        got = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (idx < 6); req_we = 1'b0; req_addr = 10'(16 + idx);
            fire = req_valid && req_ready;
            @(posedge UserCLK);
            if (fire) idx++;
            @(negedge UserCLK);
        end
        checks++;
        if (idx != 4 || req_ready !== 0 || rsp_valid !== 1 || rsp_rdata !== wdat(0)) begin
            failures++;
            $display("FAIL bp_stall got accepted=%0d ready=%b rvalid=%b rdata=%h exp 4 0 1 %h", idx, req_ready, rsp_valid, rsp_rdata, wdat(0));
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            req_valid = (idx < 6); req_we = 1'b0; req_addr = 10'(16 + idx);
            fire = req_valid && req_ready;
            if (rsp_valid) begin
                checks++;
                if (rsp_rdata !== wdat(got)) begin
                    failures++;
                    $display("FAIL bp_rsp k=%0d got %h exp %h", got, rsp_rdata, wdat(got));
                end
                got++;
            end
            @(posedge UserCLK);
            if (fire) idx++;
            @(negedge UserCLK);
        end
        req_valid = 1'b0;
        checks++;
        if (idx != 6 || got != 6) begin
            failures++;
            $display("FAIL bp_totals got accepted=%0d responses=%0d exp 6 6", idx, got);
        end
    endtask

    task automatic test_cfg_loss();
        bit found;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h010;
        cyc();
        req_addr = 10'h011;
        cyc();
        req_valid = 1'b0;
        repeat (2) cyc();
        checks++;
        if (rsp_valid !== 1) begin
            failures++;
            $display("FAIL cfg_loss_pre got rvalid=%b exp 1", rsp_valid);
        end
        configured = 1'b0;
        cyc();
        checks++;
        if (rsp_valid !== 0 || rsp_rdata !== 0 || req_ready !== 0 || clear_busy !== 0) begin
            failures++;
            $display("FAIL cfg_loss_flush got rvalid=%b rdata=%h ready=%b busy=%b exp 0 0 0 0", rsp_valid, rsp_rdata, req_ready, clear_busy);
        end
        configured = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 1100 && !found; n++) begin
            cyc();
            if (sram_men && sram_wen && sram_addr == 10'h200) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL cfg_loss_reach_200 got seen=0 exp 1");
        end
        configured = 1'b0;
        cyc();
        checks++;
        if (sram_men !== 0 || sram_wen !== 0 || sram_ren !== 0 || clear_busy !== 0 || req_ready !== 0) begin
            failures++;
            $display("FAIL cfg_loss_strobes got men=%b wen=%b ren=%b busy=%b ready=%b exp all 0", sram_men, sram_wen, sram_ren, clear_busy, req_ready);
        end
        cyc();
        test_clear();
    endtask

    task automatic test_async_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 10'(16 + i);
            cyc();
        end
        req_valid = 1'b0;
        repeat (2) cyc();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h020; req_wdata = 32'h0; req_bmask = '1;
        cyc();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1 || sram_men !== 1 || req_ready !== 1) begin
            failures++;
            $display("FAIL areset_pre got rvalid=%b men=%b ready=%b exp 1 1 1", rsp_valid, sram_men, req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 0 || sram_men !== 0 || sram_wen !== 0 || req_ready !== 0 || clear_busy !== 0) begin
            failures++;
            $display("FAIL areset_immediate got rvalid=%b men=%b wen=%b ready=%b busy=%b exp all 0", rsp_valid, sram_men, sram_wen, req_ready, clear_busy);
        end
        @(negedge UserCLK);
        rst_n = 1'b1;
        #1;
        checks++;
        if (clear_busy !== 0 || rsp_valid !== 0 || req_ready !== 0) begin
            failures++;
            $display("FAIL areset_wait_cfg got busy=%b rvalid=%b ready=%b exp 0 0 0", clear_busy, rsp_valid, req_ready);
        end
        cyc();
        checks++;
        if (clear_busy !== 1 || sram_men !== 0) begin
            failures++;
            $display("FAIL areset_restart got busy=%b men=%b exp 1 0", clear_busy, sram_men);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_cfg_loss();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
